npc_sequencer: RTL and testbench

Program-counter sequencer for the pipelined RV32 core. It owns the PC register and turns the branch unit's npc_mux_sel/pc_offset/reg_offset decision into the next fetch address. It generates IF/ID and ID/EX flush pulses on every redirect, and handles single-level interrupt entry and return. It sits between the EX-stage branch control and the fetch stage.

---
 rtl/npc_sequencer_pkg.sv | 19 +
 rtl/npc_sequencer_flush_timer.sv | 27 ++
 rtl/npc_sequencer.sv | 132 +++++++++++++
 tb/tb_npc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_sequencer_pkg.sv
// Shared encodings for the next-PC path, used by npc_sequencer and Branch_CTRL.
// Optional statistics counters are enabled with `define NPC_STATS_EN.
package npc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEL_PLUS4      = 2'b00,
        SEL_PC_OFFSET  = 2'b01,
        SEL_REG_OFFSET = 2'b10,
        SEL_INTERRUPT  = 2'b11
    } npc_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } npc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_sequencer_flush_timer.sv
// Down-counter that times how long flush stays asserted after a redirect.
module npc_sequencer_flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic done
);

    localparam logic [2:0] LOAD_VALUE = 3'(FLUSH_CYCLES - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= LOAD_VALUE;
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign done = (cnt == 3'd0);

endmodule

// File: rtl/npc_sequencer.sv
// PC register, next-PC mux, redirect flush control and single-level interrupt entry/return.
// Define NPC_STATS_EN to add the redirect_cnt / int_cnt statistics outputs.
module npc_sequencer
    import npc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic [1:0]  npc_mux_sel,
    input  logic [31:0] pc_offset,
    input  logic [31:0] reg_offset,
    input  logic        int_req,
    input  logic [31:0] int_vec,
    input  logic        int_ret,
    output logic [31:0] pc,
    output logic        flush,
    output logic        int_ack,
    output logic [31:0] epc,
`ifdef NPC_STATS_EN
    output logic [31:0] redirect_cnt,
    output logic [31:0] int_cnt,
`endif
    output logic        in_handler
);

    npc_state_e  state;
    npc_sel_e    sel;
    logic [31:0] pc_plus4;
    logic [31:0] seq_pc;
    logic [31:0] reg_target;
    logic [31:0] fallthrough_target;
    logic        take_ret;
    logic        take_int;
    logic        take_branch;
    logic        redirect;
    logic        timer_done;

    assign sel        = npc_sel_e'(npc_mux_sel);
    assign pc_plus4   = pc + 32'd4;
    assign seq_pc     = stall ? pc : pc_plus4;
    assign reg_target = reg_offset & ~32'd1;

    // Return address saved on interrupt entry ignores stall: it is where fetch would go next.
    always_comb begin
        fallthrough_target = pc_plus4;
        case (sel)
            SEL_PC_OFFSET:  fallthrough_target = pc_offset;
            SEL_REG_OFFSET: fallthrough_target = reg_target;
            default:        fallthrough_target = pc_plus4;
        endcase
    end

    assign take_ret    = (state == ST_RUN) && int_ret && in_handler;
    assign take_int    = (state == ST_RUN) && !take_ret && int_req && !in_handler;
    assign take_branch = (sel == SEL_PC_OFFSET) || (sel == SEL_REG_OFFSET);
    assign redirect    = (state == ST_RUN) && (take_ret || take_int || take_branch);

    npc_sequencer_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .clk (clk),
        .rstn(rstn),
        .load(redirect),
        .done(timer_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            int_ack    <= 1'b0;
            epc        <= 32'd0;
            in_handler <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (take_ret) begin
                        pc         <= epc;
                        in_handler <= 1'b0;
                    end else if (take_int) begin
                        epc        <= fallthrough_target;
                        pc         <= int_vec;
                        int_ack    <= 1'b1;
                        in_handler <= 1'b1;
                    end else if (take_branch) begin
                        pc <= fallthrough_target;
                    end else begin
                        pc <= seq_pc;
                    end
                    if (redirect) begin
                        state <= ST_FLUSH;
                        flush <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Squashed instructions' control inputs are not sampled here.
                    pc <= seq_pc;
                    if (timer_done) begin
                        state <= ST_RUN;
                        flush <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef NPC_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect_cnt <= 32'd0;
            int_cnt      <= 32'd0;
        end else begin
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            if (take_int) begin
                int_cnt <= int_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed self-checking bench for npc_sequencer (default parameters).
module tb_npc_sequencer;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic [1:0]  npc_mux_sel;
    logic [31:0] pc_offset;
    logic [31:0] reg_offset;
    logic        int_req;
    logic [31:0] int_vec;
    logic        int_ret;
    logic [31:0] pc;
    logic        flush;
    logic        int_ack;
    logic [31:0] epc;
    logic        in_handler;
`ifdef NPC_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] int_cnt;
`endif

    int tests_run;
    int tests_failed;

    npc_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .npc_mux_sel (npc_mux_sel),
        .pc_offset   (pc_offset),
        .reg_offset  (reg_offset),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_ret     (int_ret),
        .pc          (pc),
        .flush       (flush),
        .int_ack     (int_ack),
        .epc         (epc),
`ifdef NPC_STATS_EN
        .redirect_cnt(redirect_cnt),
        .int_cnt     (int_cnt),
`endif
        .in_handler  (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp_pc, input logic exp_flush);
        tests_run++;
        if (pc !== exp_pc) begin
            tests_failed++;
            $display("[TB] FAIL %s pc: got %h expected %h", name, pc, exp_pc);
        end
        tests_run++;
        if (flush !== exp_flush) begin
            tests_failed++;
            $display("[TB] FAIL %s flush: got %b expected %b", name, flush, exp_flush);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; npc_mux_sel = 2'b00; pc_offset = 32'd0; reg_offset = 32'd0;
        int_req = 1'b0; int_vec = 32'd0; int_ret = 1'b0;
        step();
        step();
        check_pc("reset", 32'h0000_3000, 1'b0);
        tests_run++;
        if (int_ack !== 1'b0 || in_handler !== 1'b0 || epc !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_int_state: got ack=%b inh=%b epc=%h expected 0 0 0", int_ack, in_handler, epc);
        end
`ifdef NPC_STATS_EN
        tests_run++;
        if (redirect_cnt !== 32'd0 || int_cnt !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stats: got %0d %0d expected 0 0", redirect_cnt, int_cnt);
        end
`endif
        rstn = 1'b1;
        step(); check_pc("seq1", 32'h0000_3004, 1'b0);
        step(); check_pc("seq2", 32'h0000_3008, 1'b0);
        step(); check_pc("seq3", 32'h0000_300C, 1'b0);
        step(); check_pc("seq4", 32'h0000_3010, 1'b0);
    endtask

    task automatic test_branch();
        npc_mux_sel = 2'b01; pc_offset = 32'h0000_3100;
        step(); check_pc("br_target", 32'h0000_3100, 1'b1);
        pc_offset = 32'h0000_5000;
        step(); check_pc("br_flush2_ignored", 32'h0000_3104, 1'b1);
        npc_mux_sel = 2'b00;
        step(); check_pc("br_flush_end", 32'h0000_3108, 1'b0);
    endtask

    task automatic test_reg_stall();
        npc_mux_sel = 2'b10; reg_offset = 32'h0000_3203; stall = 1'b1;
        step(); check_pc("jalr_target", 32'h0000_3202, 1'b1);
        npc_mux_sel = 2'b00; stall = 1'b0;
        step(); check_pc("jalr_flush2", 32'h0000_3206, 1'b1);
        stall = 1'b1;
        step(); check_pc("stall1", 32'h0000_3206, 1'b0);
        step(); check_pc("stall2", 32'h0000_3206, 1'b0);
        step(); check_pc("stall3", 32'h0000_3206, 1'b0);
        stall = 1'b0;
        npc_mux_sel = 2'b01; pc_offset = 32'h0000_3018;
        step(); check_pc("to_3018", 32'h0000_3018, 1'b1);
        npc_mux_sel = 2'b00;
        step();
        step(); check_pc("at_3020", 32'h0000_3020, 1'b0);
    endtask

    task automatic test_interrupt();
        int_req = 1'b1; int_vec = 32'h0000_1C00; npc_mux_sel = 2'b01; pc_offset = 32'h0000_3400;
        step(); check_pc("int_entry", 32'h0000_1C00, 1'b1);
        tests_run++;
        if (epc !== 32'h0000_3400 || int_ack !== 1'b1 || in_handler !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL int_entry_state: got epc=%h ack=%b inh=%b expected 00003400 1 1", epc, int_ack, in_handler);
        end
        npc_mux_sel = 2'b00;
        step(); check_pc("int_flush2", 32'h0000_1C04, 1'b1);
        step(); check_pc("int_flush_end", 32'h0000_1C08, 1'b0);
        step(); check_pc("int_held", 32'h0000_1C0C, 1'b0);
        tests_run++;
        if (int_ack !== 1'b0 || in_handler !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL int_no_reack: got ack=%b inh=%b expected 0 1", int_ack, in_handler);
        end
`ifdef NPC_STATS_EN
        tests_run++;
        if (redirect_cnt !== 32'd4 || int_cnt !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL int_stats: got %0d %0d expected 4 1", redirect_cnt, int_cnt);
        end
`endif
        int_req = 1'b0;
    endtask

    task automatic test_int_ret();
        int_ret = 1'b1;
        step(); check_pc("ret_target", 32'h0000_3400, 1'b1);
        tests_run++;
        if (in_handler !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ret_in_handler: got %b expected 0", in_handler);
        end
        int_ret = 1'b0;
        step(); check_pc("ret_flush2", 32'h0000_3404, 1'b1);
        step(); check_pc("ret_flush_end", 32'h0000_3408, 1'b0);
        int_ret = 1'b1;
        step(); check_pc("ret_ignored", 32'h0000_340C, 1'b0);
        int_ret = 1'b0;
    endtask

    task automatic test_wrap();
        npc_mux_sel = 2'b01; pc_offset = 32'hFFFF_FFF8;
        step(); check_pc("wrap_target", 32'hFFFF_FFF8, 1'b1);
        npc_mux_sel = 2'b00;
        step(); check_pc("wrap_fffc", 32'hFFFF_FFFC, 1'b1);
        step(); check_pc("wrap_zero", 32'h0000_0000, 1'b0);
        npc_mux_sel = 2'b11;
        step(); check_pc("sel11_plus4", 32'h0000_0004, 1'b0);
        npc_mux_sel = 2'b00;
    endtask

    task automatic test_reset_mid_flush();
        npc_mux_sel = 2'b01; pc_offset = 32'h0000_4000;
        step(); check_pc("pre_reset_redirect", 32'h0000_4000, 1'b1);
        npc_mux_sel = 2'b00;
        #2;
        rstn = 1'b0;
        #1;
        check_pc("async_reset", 32'h0000_3000, 1'b0);
        tests_run++;
        if (epc !== 32'd0 || in_handler !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_epc: got epc=%h inh=%b expected 0 0", epc, in_handler);
        end
`ifdef NPC_STATS_EN
        tests_run++;
        if (redirect_cnt !== 32'd0 || int_cnt !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_stats: got %0d %0d expected 0 0", redirect_cnt, int_cnt);
        end
`endif
        #2;
        rstn = 1'b1;
        step(); check_pc("post_reset_seq", 32'h0000_3004, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_branch();
        test_reg_stall();
        test_interrupt();
        test_int_ret();
        test_wrap();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
